// File: rtl/mdio_responder.sv
// -----------------------------------------------------------------------------
// mdio_responder
//   Clause-22 MDIO management responder. It emulates a small PHY register file
//   so that management frames from the core complete deterministically when the
//   real PHY is strapped/unmanaged or absent. Runs in the rmii_osc domain and
//   oversamples MDC (clk must be >= 8x MDC).
//
//   Ports:
//     clk        50 MHz rmii_osc clock
//     rst        synchronous active-high reset
//     mdc        raw MDC from the master (asynchronous)
//     mdio_i     raw MDIO pin input (asynchronous)
//     mdio_o     MDIO drive value
//     mdio_oe    MDIO output enable (pad tristated when 0)
//     bmcr       current register 0 contents, exported to the RMII/MII glue
//     wr_strobe  one-clk pulse after any accepted write
//     wr_addr    register address of the last accepted write
//
//   Register map: 0 BMCR (RW), 1 BMSR (RO), 2 ID1, 3 ID2 (RO), 4 ANAR (RW),
//   5 ANLPAR (RO), 31 scratch (RW). Everything else reads 0, writes ignored.
//
//   Optional feature macro: MDIO_RESP_PREAMBLE_SUPPRESS_EN
//     defined   -> any run of >=1 ones then 0 starts a frame, a frame may follow
//                  a completed frame with no preamble, BMSR bit 6 reads 1.
//     undefined -> 32 ones required before every frame, BMSR bit 6 = BMSR_VAL[6].
// -----------------------------------------------------------------------------
module mdio_responder #(
    parameter logic [4:0]  PHYAD      = 5'd1,
    parameter logic [15:0] ID1        = 16'h0007,
    parameter logic [15:0] ID2        = 16'hC0F1,
    parameter logic [15:0] BMSR_VAL   = 16'h782D,
    parameter logic [15:0] ANAR_RST   = 16'h01E1,
    parameter logic [15:0] ANLPAR_VAL = 16'h45E1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    output logic [15:0] bmcr,
    output logic        wr_strobe,
    output logic [4:0]  wr_addr
);

    localparam logic [15:0] BMCR_RST    = 16'h3100;
    localparam logic [15:0] SCRATCH_RST = 16'h0000;

`ifdef MDIO_RESP_PREAMBLE_SUPPRESS_EN
    localparam logic        PRE_SUPPRESS = 1'b1;
    localparam logic [15:0] BMSR_RD      = BMSR_VAL | 16'h0040;
`else
    localparam logic        PRE_SUPPRESS = 1'b0;
    localparam logic [15:0] BMSR_RD      = BMSR_VAL;
`endif

    typedef enum logic [3:0] {
        S_PRE, S_ST2, S_OP, S_PHY, S_REG, S_TA, S_RD, S_WR, S_SKIP
    } state_t;

    // Synchronizers and MDC edge register
    logic mdc_meta_q, mdc_sync_q, mdc_dly_q;
    logic mdio_meta_q, mdio_sync_q;
    logic mdc_rise, mdio_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            mdc_meta_q  <= 1'b0;
            mdc_sync_q  <= 1'b0;
            mdc_dly_q   <= 1'b0;
            mdio_meta_q <= 1'b1;
            mdio_sync_q <= 1'b1;
        end else begin
            mdc_meta_q  <= mdc;
            mdc_sync_q  <= mdc_meta_q;
            mdc_dly_q   <= mdc_sync_q;
            mdio_meta_q <= mdio_i;
            mdio_sync_q <= mdio_meta_q;
        end
    end

    // mdio goes through the same two-flop delay as mdc, so the synced data bit
    // lines up with the detected rise.
    assign mdc_rise = mdc_sync_q & ~mdc_dly_q;
    assign mdio_bit = mdio_sync_q;

    // State
    state_t      state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [5:0]  pre_cnt_q, pre_cnt_d;
    logic        sup_ok_q, sup_ok_d;     // last frame completed: ST may follow directly
    logic [15:0] sr_q, sr_d;
    logic [4:0]  regadr_q, regadr_d;
    logic        op_rd_q, op_rd_d;
    logic        mdio_o_q, mdio_o_d;
    logic        mdio_oe_q, mdio_oe_d;
    logic [15:0] bmcr_q, bmcr_d;
    logic [15:0] anar_q, anar_d;
    logic [15:0] scratch_q, scratch_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic [4:0]  wr_addr_q, wr_addr_d;

    logic [15:0] sr_shift;
    logic [15:0] rd_val;
    logic        start_ok;
    logic        wr_req;

    assign sr_shift = {sr_q[14:0], mdio_bit};
    assign start_ok = (pre_cnt_q == 6'd32) |
                      (PRE_SUPPRESS & (sup_ok_q | (pre_cnt_q != 6'd0)));

    always_comb begin
        rd_val = 16'h0000;
        case (regadr_q)
            5'd0:    rd_val = bmcr_q;
            5'd1:    rd_val = BMSR_RD;
            5'd2:    rd_val = ID1;
            5'd3:    rd_val = ID2;
            5'd4:    rd_val = anar_q;
            5'd5:    rd_val = ANLPAR_VAL;
            5'd31:   rd_val = scratch_q;
            default: rd_val = 16'h0000;
        endcase
    end

    // Frame FSM: every action happens on a detected MDC rise.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        pre_cnt_d = pre_cnt_q;
        sup_ok_d  = sup_ok_q;
        sr_d      = sr_q;
        regadr_d  = regadr_q;
        op_rd_d   = op_rd_q;
        mdio_o_d  = mdio_o_q;
        mdio_oe_d = mdio_oe_q;
        wr_req    = 1'b0;
        if (mdc_rise) begin
            case (state_q)
                S_PRE: begin
                    if (mdio_bit) begin
                        if (pre_cnt_q != 6'd32) pre_cnt_d = pre_cnt_q + 6'd1;
                    end else begin
                        pre_cnt_d = 6'd0;
                        if (start_ok) begin
                            state_d  = S_ST2;
                            sup_ok_d = 1'b0;
                        end
                    end
                end
                S_ST2: begin
                    bit_cnt_d = 5'd0;
                    state_d   = mdio_bit ? S_OP : S_SKIP;
                end
                S_OP: begin
                    sr_d      = sr_shift;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd1) begin
                        bit_cnt_d = 5'd0;
                        case (sr_shift[1:0])
                            2'b10:   begin op_rd_d = 1'b1; state_d = S_PHY; end
                            2'b01:   begin op_rd_d = 1'b0; state_d = S_PHY; end
                            default: state_d = S_SKIP;
                        endcase
                    end
                end
                S_PHY: begin
                    sr_d      = sr_shift;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd4) begin
                        bit_cnt_d = 5'd0;
                        state_d   = (sr_shift[4:0] == PHYAD) ? S_REG : S_SKIP;
                    end
                end
                S_REG: begin
                    sr_d      = sr_shift;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd4) begin
                        bit_cnt_d = 5'd0;
                        regadr_d  = sr_shift[4:0];
                        state_d   = S_TA;
                    end
                end
                S_TA: begin
                    if (bit_cnt_q == 5'd0) begin
                        bit_cnt_d = 5'd1;
                        if (op_rd_q) begin
                            // master has released the line: load data, drive TA0 = 0
                            sr_d      = rd_val;
                            mdio_oe_d = 1'b1;
                            mdio_o_d  = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = 5'd0;
                        state_d   = op_rd_q ? S_RD : S_WR;
                        if (op_rd_q) begin
                            mdio_o_d = sr_q[15];
                            sr_d     = {sr_q[14:0], 1'b0};
                        end
                    end
                end
                S_RD: begin
                    if (bit_cnt_q == 5'd15) begin
                        // master has just sampled D0
                        mdio_oe_d = 1'b0;
                        mdio_o_d  = 1'b1;
                        state_d   = S_PRE;
                        pre_cnt_d = 6'd0;
                        sup_ok_d  = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        mdio_o_d  = sr_q[15];
                        sr_d      = {sr_q[14:0], 1'b0};
                    end
                end
                S_WR: begin
                    sr_d = sr_shift;
                    if (bit_cnt_q == 5'd15) begin
                        wr_req    = 1'b1;
                        state_d   = S_PRE;
                        pre_cnt_d = 6'd0;
                        sup_ok_d  = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                S_SKIP: begin
                    if (bit_cnt_q == 5'd17) begin
                        state_d   = S_PRE;
                        pre_cnt_d = 6'd0;
                        sup_ok_d  = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                default: state_d = S_PRE;
            endcase
            if (state_d == S_SKIP && state_q != S_SKIP) begin
                bit_cnt_d = 5'd0;
                sup_ok_d  = 1'b0;
            end
        end
    end

    // Register file. A pending BMCR soft reset outranks any write landing on
    // the same clk; the write is dropped and no strobe is issued.
    always_comb begin
        bmcr_d      = bmcr_q;
        anar_d      = anar_q;
        scratch_d   = scratch_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        if (bmcr_q[15]) begin
            bmcr_d    = BMCR_RST;
            anar_d    = ANAR_RST;
            scratch_d = SCRATCH_RST;
        end else if (wr_req) begin
            case (regadr_q)
                5'd0: begin
                    bmcr_d = sr_shift; wr_strobe_d = 1'b1; wr_addr_d = regadr_q;
                end
                5'd4: begin
                    anar_d = sr_shift; wr_strobe_d = 1'b1; wr_addr_d = regadr_q;
                end
                5'd31: begin
                    scratch_d = sr_shift; wr_strobe_d = 1'b1; wr_addr_d = regadr_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_PRE;
            bit_cnt_q   <= 5'd0;
            pre_cnt_q   <= 6'd0;
            sup_ok_q    <= 1'b0;
            sr_q        <= 16'h0000;
            regadr_q    <= 5'd0;
            op_rd_q     <= 1'b0;
            mdio_o_q    <= 1'b1;
            mdio_oe_q   <= 1'b0;
            bmcr_q      <= BMCR_RST;
            anar_q      <= ANAR_RST;
            scratch_q   <= SCRATCH_RST;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 5'd0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            pre_cnt_q   <= pre_cnt_d;
            sup_ok_q    <= sup_ok_d;
            sr_q        <= sr_d;
            regadr_q    <= regadr_d;
            op_rd_q     <= op_rd_d;
            mdio_o_q    <= mdio_o_d;
            mdio_oe_q   <= mdio_oe_d;
            bmcr_q      <= bmcr_d;
            anar_q      <= anar_d;
            scratch_q   <= scratch_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
        end
    end

    assign mdio_o    = mdio_o_q;
    assign mdio_oe   = mdio_oe_q;
    assign bmcr      = bmcr_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;

endmodule

// File: tb/tb_mdio_responder.sv
// -----------------------------------------------------------------------------
// tb_mdio_responder
//   Bench acting as the MDIO master at 2.5 MHz MDC (20 clk per bit) against a
//   50 MHz clk. The shared line is modelled with a pull-up: DUT drive wins when
//   mdio_oe is set, otherwise the master's drive, otherwise 1. Read data is
//   checked through an expected-value queue; oe activity and write strobes are
//   counted by monitors on the falling clk edge.
// -----------------------------------------------------------------------------
module tb_mdio_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mdc = 1'b0;
    logic        m_en = 1'b0;
    logic        m_drv = 1'b1;
    logic        mdio_line;
    logic        mdio_o, mdio_oe, wr_strobe;
    logic [15:0] bmcr;
    logic [4:0]  wr_addr;

    assign mdio_line = mdio_oe ? mdio_o : (m_en ? m_drv : 1'b1);

    mdio_responder dut (
        .clk       (clk),
        .rst       (rst),
        .mdc       (mdc),
        .mdio_i    (mdio_line),
        .mdio_o    (mdio_o),
        .mdio_oe   (mdio_oe),
        .bmcr      (bmcr),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr)
    );

    always #10 clk = ~clk;

`ifdef MDIO_RESP_PREAMBLE_SUPPRESS_EN
    localparam logic [15:0] BMSR_EXP = 16'h786D;
    localparam bit          SUP      = 1'b1;
`else
    localparam logic [15:0] BMSR_EXP = 16'h782D;
    localparam bit          SUP      = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int oe_cycles = 0;
    int strb_cnt = 0;
    logic [4:0] strb_addr = '0;
    logic [15:0] exp_q[$];

    always @(negedge clk) begin
        if (mdio_oe) oe_cycles++;
        if (wr_strobe) begin
            strb_cnt++;
            strb_addr = wr_addr;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Low half of a bit: drive, wait, sample the line, then raise MDC.
    task automatic bit_lo(input logic drv, input logic rel, output logic smp);
        @(negedge clk);
        mdc   = 1'b0;
        m_en  = ~rel;
        m_drv = drv;
        repeat (10) @(negedge clk);
        smp = mdio_line;
        mdc = 1'b1;
    endtask

    task automatic hold_hi();
        repeat (9) @(negedge clk);
    endtask

    task automatic clk_bit(input logic drv, input logic rel, output logic smp);
        bit_lo(drv, rel, smp);
        hold_hi();
    endtask

    task automatic frame(input bit wr, input logic [4:0] pa, input logic [4:0] ra,
                         input logic [15:0] wd, input int pre, input bit resp,
                         input int rst_at, output logic [15:0] rd, output logic ta0);
        logic [13:0] hdr;
        logic s;
        rd  = '0;
        ta0 = 1'b1;
        hdr = {2'b01, (wr ? 2'b01 : 2'b10), pa, ra};
        for (int i = 0; i < pre; i++) clk_bit(1'b1, 1'b0, s);
        for (int i = 13; i >= 0; i--) clk_bit(hdr[i], 1'b0, s);
        if (wr) begin
            clk_bit(1'b1, 1'b0, s);
            clk_bit(1'b0, 1'b0, s);
            for (int i = 15; i >= 0; i--) clk_bit(wd[i], 1'b0, s);
        end else begin
            bit_lo(1'b1, 1'b1, s);
            repeat (2) @(negedge clk);
            if (resp) chk("oe_early_at_TA", {31'd0, mdio_oe}, 32'd0);
            repeat (2) @(negedge clk);
            if (resp) chk("oe_rise_after_TA", {31'd0, mdio_oe}, 32'd1);
            repeat (5) @(negedge clk);
            clk_bit(1'b1, 1'b1, s);
            ta0 = s;
            for (int k = 1; k <= 16; k++) begin
                bit_lo(1'b1, 1'b1, s);
                rd = {rd[14:0], s};
                if (k == rst_at) begin
                    repeat (5) @(negedge clk);
                    chk("oe_before_rst", {31'd0, mdio_oe}, 32'd1);
                    rst = 1'b1;
                    @(negedge clk);
                    chk("oe_after_rst", {31'd0, mdio_oe}, 32'd0);
                    rst = 1'b0;
                    repeat (3) @(negedge clk);
                end else if (k == 16 && rst_at == 0 && resp) begin
                    repeat (4) @(negedge clk);
                    chk("oe_drop_after_D0", {31'd0, mdio_oe}, 32'd0);
                    repeat (5) @(negedge clk);
                end else begin
                    hold_hi();
                end
            end
        end
        @(negedge clk);
        mdc  = 1'b0;
        m_en = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    typedef struct {
        bit          wr;
        logic [4:0]  pa;
        logic [4:0]  ra;
        logic [15:0] wd;
        int          pre;
        bit          resp;
        bit          strb;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[22];

    // Runs one transaction and checks it against its expectations.
    task automatic run(input string nm, input vec_t v);
        logic [15:0] rd, want;
        logic ta0;
        int s0;
        s0 = strb_cnt;
        oe_cycles = 0;
        if (!v.wr && v.resp) exp_q.push_back(v.exp);
        frame(v.wr, v.pa, v.ra, v.wd, v.pre, v.resp, 0, rd, ta0);
        if (v.wr) begin
            chk({nm, "_strobes"}, strb_cnt - s0, {31'd0, v.strb});
            if (v.strb) chk({nm, "_wr_addr"}, {27'd0, strb_addr}, {27'd0, v.ra});
            chk({nm, "_oe_idle"}, oe_cycles, 32'd0);
        end else if (v.resp) begin
            want = exp_q.pop_front();
            chk({nm, "_data"}, {16'd0, rd}, {16'd0, want});
            chk({nm, "_ta0"}, {31'd0, ta0}, 32'd0);
            chk({nm, "_oe_cycles"}, oe_cycles, 32'd340);
        end else begin
            chk({nm, "_oe_idle"}, oe_cycles, 32'd0);
        end
    endtask

    function automatic vec_t rv(input logic [4:0] pa, input logic [4:0] ra, input int pre,
                                input bit resp, input logic [15:0] exp);
        vec_t v;
        v = '{1'b0, pa, ra, 16'h0000, pre, resp, 1'b0, exp};
        return v;
    endfunction

    function automatic vec_t wv(input logic [4:0] pa, input logic [4:0] ra,
                                input logic [15:0] wd, input bit strb);
        vec_t v;
        v = '{1'b1, pa, ra, wd, 32, 1'b0, strb, 16'h0000};
        return v;
    endfunction

    initial begin
        logic [15:0] rd;
        logic ta0;
        int s0;

        vecs[0]  = rv(5'd1, 5'd2,  32, 1'b1, 16'h0007);
        vecs[1]  = rv(5'd1, 5'd3,  32, 1'b1, 16'hC0F1);
        vecs[2]  = rv(5'd1, 5'd0,  32, 1'b1, 16'h3100);
        vecs[3]  = rv(5'd1, 5'd1,  32, 1'b1, BMSR_EXP);
        vecs[4]  = rv(5'd1, 5'd5,  32, 1'b1, 16'h45E1);
        vecs[5]  = rv(5'd1, 5'd4,  32, 1'b1, 16'h01E1);
        vecs[6]  = rv(5'd1, 5'd31, 32, 1'b1, 16'h0000);
        vecs[7]  = rv(5'd1, 5'd7,  32, 1'b1, 16'h0000);
        vecs[8]  = wv(5'd1, 5'd4,  16'hABCD, 1'b1);
        vecs[9]  = rv(5'd1, 5'd4,  32, 1'b1, 16'hABCD);
        vecs[10] = rv(5'd2, 5'd1,  32, 1'b0, 16'h0000);
        vecs[11] = rv(5'd1, 5'd1,  32, 1'b1, BMSR_EXP);
        vecs[12] = wv(5'd1, 5'd1,  16'hFFFF, 1'b0);
        vecs[13] = rv(5'd1, 5'd1,  32, 1'b1, BMSR_EXP);
        vecs[14] = wv(5'd1, 5'd31, 16'h1234, 1'b1);
        vecs[15] = rv(5'd1, 5'd31, 32, 1'b1, 16'h1234);
        vecs[16] = wv(5'd1, 5'd0,  16'h1140, 1'b1);
        vecs[17] = rv(5'd1, 5'd0,  32, 1'b1, 16'h1140);
        vecs[18] = wv(5'd3, 5'd4,  16'h0000, 1'b0);
        vecs[19] = rv(5'd1, 5'd4,  32, 1'b1, 16'hABCD);
        vecs[20] = rv(5'd1, 5'd3,  20, SUP,  16'hC0F1);
        vecs[21] = rv(5'd1, 5'd3,  32, 1'b1, 16'hC0F1);

        // Reset state
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mdio_oe",   {31'd0, mdio_oe},   32'd0);
        chk("rst_mdio_o",    {31'd0, mdio_o},    32'd1);
        chk("rst_bmcr",      {16'd0, bmcr},      32'h3100);
        chk("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
        chk("rst_wr_addr",   {27'd0, wr_addr},   32'd0);

        for (int i = 0; i < 22; i++) run($sformatf("v%0d", i), vecs[i]);

        // BMCR soft reset restores all RW registers
        chk("bmcr_out_1140", {16'd0, bmcr}, 32'h1140);
        run("scr_w", wv(5'd1, 5'd31, 16'h1234, 1'b1));
        run("bmcr_sr_w", wv(5'd1, 5'd0, 16'h8000, 1'b1));
        chk("bmcr_after_sr", {16'd0, bmcr}, 32'h3100);
        run("scr_after_sr", rv(5'd1, 5'd31, 32, 1'b1, 16'h0000));
        run("bmcr_rd_sr",   rv(5'd1, 5'd0,  32, 1'b1, 16'h3100));
        run("anar_after_sr", rv(5'd1, 5'd4, 32, 1'b1, 16'h01E1));

        // rst on the 8th data rise of a read
        run("anar_w2", wv(5'd1, 5'd4, 16'h5555, 1'b1));
        run("bmcr_w2", wv(5'd1, 5'd0, 16'h0140, 1'b1));
        s0 = strb_cnt;
        frame(1'b0, 5'd1, 5'd2, 16'h0000, 32, 1'b1, 8, rd, ta0);
        chk("rst_mid_bmcr",    {16'd0, bmcr},    32'h3100);
        chk("rst_mid_wr_addr", {27'd0, wr_addr}, 32'd0);
        chk("rst_mid_strobes", strb_cnt - s0,    32'd0);
        run("post_rst_bmcr", rv(5'd1, 5'd0, 32, 1'b1, 16'h3100));
        run("post_rst_anar", rv(5'd1, 5'd4, 32, 1'b1, 16'h01E1));

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: got timeout want completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

endmodule
